// File: rtl/csr_regfile_v2.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc etc., counters, live mip.
// Ports: ex read/RMW port, clint read+write port, counter events, irq in.
module csr_regfile_v2 #(
  parameter int          NUM_HPM  = 2,
  parameter int          CNT_W    = 64,
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [1:0]  ex_op_i,
  input  logic [11:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic [31:0] ex_rdata_o,
  output logic        ex_illegal_o,
  input  logic        clint_we_i,
  input  logic [11:0] clint_waddr_i,
  input  logic [11:0] clint_raddr_i,
  input  logic [31:0] clint_data_i,
  output logic [31:0] clint_data_o,
  input  logic        instret_i,
  input  logic [(NUM_HPM>0 ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic [2:0]  irq_i,
  output logic        int_req_o,
  output logic        global_int_en_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o
);

  localparam int NCNT = 2 + NUM_HPM;
  localparam int IW   = $clog2(NCNT);
  localparam int HI_W = CNT_W - 32;
  localparam logic [6:0] HPM_END = 7'(3 + NUM_HPM);
  localparam logic [31:0] INH_MASK =
    32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] minh_q, minh_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        int_req_q, int_req_d;
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] mstatus_v, mie_v, mip_v;

  assign mstatus_v = {19'd0, 2'b11, 3'd0, mst_mpie_q,
                      3'd0, mst_mie_q, 3'd0};
  assign mie_v = {20'd0, mie_q[2], 3'd0, mie_q[1],
                  3'd0, mie_q[0], 3'd0};
  assign mip_v = {20'd0, irq_i[2], 3'd0, irq_i[1],
                  3'd0, irq_i[0], 3'd0};

  // Counter slot 0 = mcycle, 1 = minstret, 2+n = mhpmcounter(3+n).
  function automatic logic cnt_hit(input logic [11:0] a);
    logic [6:0] k;
    k = a[6:0];
    return (a[11:8] == 4'hB || a[11:8] == 4'hC) &&
           (k == 7'd0 || (k >= 7'd2 && k < HPM_END));
  endfunction

  function automatic logic cnt_wa(input logic [11:0] a);
    return a[11:8] == 4'hB && cnt_hit(a);
  endfunction

  function automatic logic [IW-1:0] cnt_idx(input logic [11:0] a);
    logic [6:0] j;
    j = (a[6:0] == 7'd0) ? 7'd0 : a[6:0] - 7'd1;
    return j[IW-1:0];
  endfunction

  function automatic logic [31:0] cnt_half(
    input logic [CNT_W-1:0] v,
    input logic             hi
  );
    logic [63:0] t;
    t = 64'(v);
    return hi ? t[63:32] : t[31:0];
  endfunction

  function automatic logic is_ro(input logic [11:0] a);
    return a == 12'h301 || a == 12'h344 ||
           a == 12'hF14 || a[11:8] == 4'hC;
  endfunction

  // Returns {mapped, value}.
  function automatic logic [32:0] rd(input logic [11:0] a);
    logic [32:0] r;
    r = '0;
    case (a)
      12'h300: r = {1'b1, mstatus_v};
      12'h301: r = {1'b1, MISA_VAL};
      12'h304: r = {1'b1, mie_v};
      12'h305: r = {1'b1, mtvec_q};
      12'h320: r = {1'b1, minh_q};
      12'h340: r = {1'b1, mscratch_q};
      12'h341: r = {1'b1, mepc_q};
      12'h342: r = {1'b1, mcause_q};
      12'h344: r = {1'b1, mip_v};
      12'hF14: r = {1'b1, HART_ID};
      default: begin
        if (cnt_hit(a))
          r = {1'b1, cnt_half(cnt_q[cnt_idx(a)], a[7])};
      end
    endcase
    return r;
  endfunction

  logic [32:0] ex_rd, cl_rd;
  logic        ex_ill, ex_wen;
  logic [31:0] ex_new;

  assign ex_rd  = rd(ex_addr_i);
  assign cl_rd  = rd(clint_raddr_i);
  assign ex_ill = !ex_rd[32] ||
                  (ex_we_i && (is_ro(ex_addr_i) || ex_op_i == 2'b11));
  assign ex_wen = ex_we_i && !ex_ill;

  always_comb begin
    ex_new = ex_wdata_i;
    unique case (1'b1)
      ex_op_i == 2'b01: ex_new = ex_rd[31:0] | ex_wdata_i;
      ex_op_i == 2'b10: ex_new = ex_rd[31:0] & ~ex_wdata_i;
      default:          ex_new = ex_wdata_i;
    endcase
  end

  // Port 0 = clint, port 1 = ex; ex is applied last so it wins.
  logic [1:0]       wp_we;
  logic [1:0][11:0] wp_a;
  logic [1:0][31:0] wp_d;

  assign wp_we = {ex_wen, clint_we_i};
  assign wp_a  = {ex_addr_i, clint_waddr_i};
  assign wp_d  = {ex_new, clint_data_i};

  logic [NCNT-1:0] inc, cnt_wr;

  always_comb begin
    inc    = '0;
    inc[0] = !minh_q[0];
    inc[1] = instret_i && !minh_q[2];
    for (int n = 0; n < NUM_HPM; n++)
      inc[2+n] = hpm_event_i[n] && !minh_q[3+n];
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    minh_d     = minh_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    cnt_wr     = '0;
    // A written counter holds both halves; only the written half moves.
    for (int p = 0; p < 2; p++)
      if (wp_we[p] && cnt_wa(wp_a[p]))
        cnt_wr[cnt_idx(wp_a[p])] = 1'b1;
    for (int i = 0; i < NCNT; i++)
      cnt_d[i] = cnt_wr[i] ? cnt_q[i]
                           : cnt_q[i] + CNT_W'(inc[i]);
    for (int p = 0; p < 2; p++) begin
      if (wp_we[p]) begin
        case (wp_a[p])
          12'h300: begin
            mst_mie_d  = wp_d[p][3];
            mst_mpie_d = wp_d[p][7];
          end
          12'h304: mie_d = {wp_d[p][11], wp_d[p][7], wp_d[p][3]};
          12'h305: mtvec_d = wp_d[p];
          12'h320: minh_d = wp_d[p] & INH_MASK;
          12'h340: mscratch_d = wp_d[p];
          12'h341: mepc_d = {wp_d[p][31:2], 2'b00};
          12'h342: mcause_d = wp_d[p];
          default: begin
            if (cnt_wa(wp_a[p])) begin
              if (wp_a[p][7])
                cnt_d[cnt_idx(wp_a[p])][CNT_W-1:32] =
                  wp_d[p][HI_W-1:0];
              else
                cnt_d[cnt_idx(wp_a[p])][31:0] = wp_d[p];
            end
          end
        endcase
      end
    end
    // Uses the post-write enables so an enable change acts at once.
    int_req_d = mst_mie_d && |(mie_d & irq_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      minh_q     <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      cnt_q      <= '0;
      int_req_q  <= 1'b0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      minh_q     <= minh_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      cnt_q      <= cnt_d;
      int_req_q  <= int_req_d;
    end
  end

  assign ex_rdata_o   = rst ? '0 : ex_rd[31:0];
  assign ex_illegal_o = !rst && ex_ill;
  assign clint_data_o = rst ? '0 :
    (clint_we_i && clint_waddr_i == clint_raddr_i) ? clint_data_i
                                                   : cl_rd[31:0];

  assign int_req_o       = int_req_q;
  assign global_int_en_o = mst_mie_q;
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = rst ? '0 : mstatus_v;

endmodule

// File: tb/tb_csr_regfile_v2.sv
// Self-checking bench for csr_regfile_v2: vector table, directed
// corner sequences, then random traffic against a reference model.
module tb_csr_regfile_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we;
  logic [1:0]  ex_op;
  logic [11:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_rdata;
  logic        ex_ill;
  logic        clint_we;
  logic [11:0] clint_waddr;
  logic [11:0] clint_raddr;
  logic [31:0] clint_data;
  logic [31:0] clint_rdata;
  logic        instret;
  logic [1:0]  hpm;
  logic [2:0]  irq;
  logic        int_req;
  logic        gie;
  logic [31:0] mtvec, mepc, mstatus;

  int errors = 0;
  int checks = 0;

  csr_regfile_v2 dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_op_i(ex_op),
    .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_rdata_o(ex_rdata), .ex_illegal_o(ex_ill),
    .clint_we_i(clint_we), .clint_waddr_i(clint_waddr),
    .clint_raddr_i(clint_raddr), .clint_data_i(clint_data),
    .clint_data_o(clint_rdata),
    .instret_i(instret), .hpm_event_i(hpm), .irq_i(irq),
    .int_req_o(int_req), .global_int_en_o(gie),
    .mtvec_o(mtvec), .mepc_o(mepc), .mstatus_o(mstatus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ex_we = 0; ex_op = 0; ex_addr = 0; ex_wdata = 0;
    clint_we = 0; clint_waddr = 0; clint_raddr = 0;
    clint_data = 0; instret = 0; hpm = 0; irq = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_wr(input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] d);
    ex_we = 1; ex_op = op; ex_addr = a; ex_wdata = d;
    tick();
    ex_we = 0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [0:4095];
  logic [63:0] m_cnt [4];
  logic        m_ireq;

  task automatic m_reset();
    for (int i = 0; i < 4096; i++) m_reg[i] = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ireq = 0;
  endtask

  function automatic logic [31:0] m_wmask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0888;
      12'h305: return 32'hFFFF_FFFF;
      12'h320: return 32'h0000_001D;
      12'h340: return 32'hFFFF_FFFF;
      12'h341: return 32'hFFFF_FFFC;
      12'h342: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_cidx(input logic [11:0] a);
    int off;
    if (a[11:8] != 4'hB && a[11:8] != 4'hC) return -1;
    off = int'(a[6:0]);
    if (off == 0) return 0;
    if (off == 2) return 1;
    if (off == 3 || off == 4) return off - 1;
    return -1;
  endfunction

  function automatic logic m_ro(input logic [11:0] a);
    return a == 12'h301 || a == 12'h344 ||
           a == 12'hF14 || a[11:8] == 4'hC;
  endfunction

  function automatic logic m_mapped(input logic [11:0] a);
    return m_wmask(a) != 0 || a == 12'h301 || a == 12'h344 ||
           a == 12'hF14 || m_cidx(a) >= 0;
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(irq[2]) << 11) | (32'(irq[1]) << 7) |
           (32'(irq[0]) << 3);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int ci;
    ci = m_cidx(a);
    if (a == 12'h300) return m_reg[a] | 32'h1800;
    if (m_wmask(a) != 0) return m_reg[a];
    if (a == 12'h301) return 32'h4000_0100;
    if (a == 12'h344) return m_mip();
    if (ci >= 0) return a[7] ? m_cnt[ci][63:32] : m_cnt[ci][31:0];
    return 32'h0;
  endfunction

  function automatic logic m_illegal(input logic we,
      input logic [1:0] op, input logic [11:0] a);
    return !m_mapped(a) || (we && (m_ro(a) || op == 2'b11));
  endfunction

  task automatic m_step();
    logic [63:0] nc [4];
    logic [31:0] old, nv, inh;
    logic        exw, up;
    logic        we [2];
    logic [11:0] a [2];
    logic [31:0] d [2];
    int          ci;
    inh = m_reg[12'h320];
    old = m_read(ex_addr);
    exw = ex_we && !m_illegal(ex_we, ex_op, ex_addr);
    nv  = (ex_op == 2'b01) ? (old | ex_wdata) :
          (ex_op == 2'b10) ? (old & ~ex_wdata) : ex_wdata;
    we[0] = clint_we; a[0] = clint_waddr; d[0] = clint_data;
    we[1] = exw;      a[1] = ex_addr;     d[1] = nv;
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      up = !inh[0];
      else if (i == 1) up = instret && !inh[2];
      else             up = hpm[i-2] && !inh[i+1];
      nc[i] = m_cnt[i] + 64'(up);
    end
    for (int p = 0; p < 2; p++) begin
      ci = m_cidx(a[p]);
      if (we[p] && !m_ro(a[p]) && ci >= 0) nc[ci] = m_cnt[ci];
    end
    for (int p = 0; p < 2; p++) begin
      ci = m_cidx(a[p]);
      if (we[p] && !m_ro(a[p])) begin
        if (m_wmask(a[p]) != 0)
          m_reg[a[p]] = d[p] & m_wmask(a[p]);
        else if (ci >= 0) begin
          if (a[p][7]) nc[ci][63:32] = d[p];
          else         nc[ci][31:0]  = d[p];
        end
      end
    end
    for (int i = 0; i < 4; i++) m_cnt[i] = nc[i];
    m_ireq = m_reg[12'h300][3] &&
             ((m_reg[12'h304] & m_mip()) != 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic we, input logic [1:0] op,
      input logic [11:0] a, input logic [31:0] wd,
      input logic chk_rd, input logic [31:0] rd, input logic ill);
    vec_t v;
    v.we = we; v.op = op; v.addr = a; v.wd = wd;
    v.chk_rd = chk_rd; v.rd = rd; v.ill = ill;
    tv.push_back(v);
  endtask

  logic [11:0] pool [20];

  initial begin
    idle();
    rst = 1;
    #12;
    ex_addr = 12'h301; clint_raddr = 12'h301;
    #1;
    chk("rst_int_req", int_req, 0);
    chk("rst_mtvec", mtvec, 0);
    chk("rst_mepc", mepc, 0);
    chk("rst_mstatus", mstatus, 0);
    chk("rst_gie", gie, 0);
    chk("rst_ex_rdata", ex_rdata, 0);
    chk("rst_clint_data", clint_rdata, 0);
    ex_addr = 12'h7C0;
    #1;
    chk("rst_ex_illegal", ex_ill, 0);
    @(posedge clk);
    #1;
    rst = 0;
    idle();

    add(1, 0, 12'h320, 32'h1D,  1, 32'h0,    0);
    add(1, 0, 12'h304, 32'h888, 1, 32'h0,    0);
    add(1, 1, 12'h300, 32'h008, 1, 32'h1800, 0);
    add(1, 2, 12'h304, 32'h880, 1, 32'h888,  0);
    add(0, 0, 12'h300, 32'h0,   1, 32'h1808, 0);
    add(0, 0, 12'h304, 32'h0,   1, 32'h008,  0);
    add(1, 0, 12'hC00, 32'h5,   0, 32'h0,    1);
    add(1, 0, 12'hF14, 32'h9,   1, 32'h0,    1);
    add(0, 0, 12'h7C0, 32'h0,   1, 32'h0,    1);
    add(1, 3, 12'h340, 32'h1234, 1, 32'h0,   1);
    add(0, 0, 12'h340, 32'h0,   1, 32'h0,    0);
    add(1, 0, 12'h341, 32'h1237, 1, 32'h0,   0);
    add(0, 0, 12'h341, 32'h0,   1, 32'h1234, 0);
    add(0, 0, 12'h301, 32'h0,   1, 32'h4000_0100, 0);
    add(1, 1, 12'h344, 32'hFFF, 1, 32'h0,    1);
    add(0, 0, 12'h344, 32'h0,   1, 32'h0,    0);
    add(0, 0, 12'hF14, 32'h0,   1, 32'h0,    0);
    add(0, 0, 12'h320, 32'h0,   1, 32'h1D,   0);
    add(1, 0, 12'hB01, 32'h1,   1, 32'h0,    1);
    add(0, 0, 12'hB05, 32'h0,   1, 32'h0,    1);

    foreach (tv[i]) begin
      ex_we = tv[i].we; ex_op = tv[i].op;
      ex_addr = tv[i].addr; ex_wdata = tv[i].wd;
      @(negedge clk);
      if (tv[i].chk_rd)
        chk($sformatf("vec%0d_rdata", i), ex_rdata, tv[i].rd);
      chk($sformatf("vec%0d_illegal", i), ex_ill, tv[i].ill);
      tick();
    end
    idle();

    // interrupt request and enable changes
    ex_wr(0, 12'h304, 32'h80);
    irq = 3'b010;
    @(negedge clk);
    chk("irq_not_yet", int_req, 0);
    tick();
    chk("irq_asserted", int_req, 1);
    ex_wr(2, 12'h300, 32'h8);
    chk("irq_mie_clr", int_req, 0);
    chk("gie_clr", gie, 0);
    ex_wr(1, 12'h300, 32'h8);
    chk("irq_mie_set", int_req, 1);
    irq = 3'b000;
    tick();
    chk("irq_dropped", int_req, 0);

    // ex and clint collisions
    clint_we = 1; clint_waddr = 12'h341; clint_data = 32'hB0;
    ex_wr(0, 12'h341, 32'hA0);
    chk("collide_mepc", mepc, 32'hA0);
    clint_waddr = 12'h340; clint_data = 32'h55;
    ex_wr(0, 12'h341, 32'hC0);
    clint_we = 0;
    chk("split_mepc", mepc, 32'hC0);
    clint_raddr = 12'h340;
    #1;
    chk("split_mscratch", clint_rdata, 32'h55);
    clint_we = 1; clint_waddr = 12'h305; clint_raddr = 12'h305;
    clint_data = 32'hDEAD_BEEF;
    #1;
    chk("clint_fwd", clint_rdata, 32'hDEAD_BEEF);
    chk("mtvec_before", mtvec, 32'h0);
    tick();
    clint_we = 0;
    chk("mtvec_after", mtvec, 32'hDEAD_BEEF);

    // wrap and write-override
    ex_wr(0, 12'h320, 32'h0);
    ex_wr(0, 12'hB80, 32'hFFFF_FFFF);
    ex_wr(0, 12'hB00, 32'hFFFF_FFFE);
    ex_addr = 12'hB00; clint_raddr = 12'hB80;
    @(negedge clk);
    chk("wrap_lo0", ex_rdata, 32'hFFFF_FFFE);
    chk("wrap_hi0", clint_rdata, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    chk("wrap_lo1", ex_rdata, 32'hFFFF_FFFF);
    chk("wrap_hi1", clint_rdata, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    chk("wrap_lo2", ex_rdata, 32'h0);
    chk("wrap_hi2", clint_rdata, 32'h0);
    tick();

    // minstret inhibit
    ex_wr(0, 12'h320, 32'h5);
    ex_wr(0, 12'hB02, 32'h0);
    ex_wr(0, 12'hB82, 32'h0);
    instret = 1;
    repeat (4) tick();
    instret = 0;
    ex_addr = 12'hB02;
    @(negedge clk);
    chk("inhibit_held", ex_rdata, 32'h0);
    tick();
    ex_wr(0, 12'h320, 32'h0);
    instret = 1;
    repeat (4) tick();
    instret = 0;
    ex_addr = 12'hB02; clint_raddr = 12'hB82;
    @(negedge clk);
    chk("instret_cnt", ex_rdata, 32'h4);
    chk("instret_hi", clint_rdata, 32'h0);
    tick();

    // asynchronous reset mid-operation
    irq = 3'b010;
    tick();
    chk("pre_rst_irq", int_req, 1);
    ex_we = 1; ex_op = 0; ex_addr = 12'h340; ex_wdata = 32'h77;
    #2;
    rst = 1;
    #1;
    chk("arst_int_req", int_req, 0);
    chk("arst_mtvec", mtvec, 0);
    chk("arst_mepc", mepc, 0);
    chk("arst_mstatus", mstatus, 0);
    chk("arst_gie", gie, 0);
    chk("arst_rdata", ex_rdata, 0);
    tick();
    idle();
    rst = 0;
    ex_addr = 12'hB00; clint_raddr = 12'h340;
    @(negedge clk);
    chk("rel_mcycle0", ex_rdata, 32'h0);
    chk("rel_discard", clint_rdata, 32'h0);
    tick();
    @(negedge clk);
    chk("rel_mcycle1", ex_rdata, 32'h1);
    chk("rel_int_req", int_req, 0);
    tick();
    @(negedge clk);
    chk("rel_mcycle2", ex_rdata, 32'h2);

    // random traffic against the model from a fresh reset
    pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320,
             12'h340, 12'h341, 12'h342, 12'h344, 12'hB00,
             12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB84,
             12'hC00, 12'hC83, 12'hF14, 12'h7C0, 12'hB05};
    tick();
    rst = 1;
    tick();
    rst = 0;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      ex_we = 1'($urandom_range(0, 1));
      ex_op = 2'($urandom_range(0, 3));
      ex_addr = pool[$urandom_range(0, 19)];
      ex_wdata = $urandom();
      clint_we = ($urandom_range(0, 3) == 0);
      clint_waddr = pool[$urandom_range(0, 19)];
      clint_raddr = ($urandom_range(0, 3) == 0) ? clint_waddr
                    : pool[$urandom_range(0, 19)];
      clint_data = $urandom();
      instret = 1'($urandom_range(0, 1));
      hpm = 2'($urandom_range(0, 3));
      irq = 3'($urandom_range(0, 7));
      @(negedge clk);
      chk($sformatf("rnd%0d_rdata", c), ex_rdata, m_read(ex_addr));
      chk($sformatf("rnd%0d_illegal", c), ex_ill,
          m_illegal(ex_we, ex_op, ex_addr));
      chk($sformatf("rnd%0d_clint", c), clint_rdata,
          (clint_we && clint_waddr == clint_raddr) ? clint_data
                                                   : m_read(clint_raddr));
      tick();
      m_step();
      chk($sformatf("rnd%0d_int_req", c), int_req, m_ireq);
      chk($sformatf("rnd%0d_mtvec", c), mtvec, m_reg[12'h305]);
      chk($sformatf("rnd%0d_mepc", c), mepc, m_reg[12'h341]);
      chk($sformatf("rnd%0d_mstatus", c), mstatus,
          m_reg[12'h300] | 32'h1800);
      chk($sformatf("rnd%0d_gie", c), gie, m_reg[12'h300][3]);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
